psram_arbiter: RTL and testbench
================================

// Module: psram_arbiter
//
// PURPOSE
//   Shares one asynchronous PSRAM controller between three requesters (p0 = APF bridge
//   loader, p1 = CPU PRG/WRAM, p2 = PPU CHR). Latches one-cycle requests per port and
//   arbitrates among pending ports, fixed-priority or round-robin.
//   Drives the controller's write_en/read_en handshake, routes read data and completion
//   back to the winner. Sits between core memory mappers and the PSRAM controller.
//
// PARAMETERS
//   FIXED_PRIORITY  0  0: round-robin among pending ports; 1: strict p0 > p1 > p2
//   RESET_GRANT     2  initial round-robin pointer (last granted port), 0..2
//
// PORTS
//   clk             in   1   system clock, same clock as the PSRAM controller
//   reset           in   1   asynchronous, active-high reset
//   pN_req          in   1   (N=0..2) one-cycle request strobe, sampled only while pN_busy=0
//   pN_we           in   1   1 = write, 0 = read; sampled with pN_req
//   pN_bank         in   1   PSRAM bank select; sampled with pN_req
//   pN_addr         in   22  word address; sampled with pN_req
//   pN_wdata        in   16  write data; sampled with pN_req
//   pN_be           in   2   byte enables {high,low}; sampled with pN_req; reads ignore it
//   pN_busy         out  1   request latched and not yet completed
//   pN_done         out  1   one-cycle pulse on completion (read or write)
//   pN_rdata        out  16  read data; valid while pN_done=1 for a read, held after
//   ctrl_bank_sel   out  1   to controller bank_sel
//   ctrl_addr       out  22  to controller addr
//   ctrl_data_in    out  16  to controller data_in
//   ctrl_write_high_byte out 1  to controller; ctrl_write_low_byte  out 1  to controller
//   ctrl_write_en   out  1   to controller write_en (level, held until ack)
//   ctrl_read_en    out  1   to controller read_en (level, held until ack)
//   ctrl_write_ack  in   1   from controller
//   ctrl_read_ack   in   1   from controller
//   ctrl_read_avail in   1   from controller
//   ctrl_data_out   in   16  from controller
//   ctrl_busy       in   1   from controller
//
// BEHAVIOUR
//   Reset: all outputs 0, all pending cleared, state IDLE, rr pointer = RESET_GRANT.
//   Latch: pN_req=1 while pN_busy=0 -> payload stored, pN_busy=1 next cycle. A req while
//     pN_busy=1 is ignored: no overwrite, no queueing.
//   FSM IDLE: if any pending and ctrl_busy=0, choose the winner.
//     FIXED_PRIORITY=1: lowest index wins.
//     FIXED_PRIORITY=0: first pending in order ptr+1, ptr+2, ptr (mod 3).
//     Register the winner's payload onto ctrl_*; assert ctrl_write_en or ctrl_read_en.
//     Set ptr = winner. Go to ISSUE.
//   ISSUE: hold the ctrl_* payload and enable. On ctrl_write_ack=1 or ctrl_read_ack=1,
//     deassert both enables that cycle and go to WAIT. Enables must drop before the
//     controller returns to idle, so one command never launches twice.
//   WAIT (read): on ctrl_read_avail=1, pW_rdata <= ctrl_data_out, pulse pW_done,
//     clear pending(W), go to IDLE.
//   WAIT (write): when ctrl_write_ack=0 and ctrl_busy=0, pulse pW_done, clear pending(W),
//     go to IDLE.
//   pW_done and the fall of pW_busy occur in the same cycle. A new pW_req is accepted in
//     that cycle.
//   The earliest re-grant is the cycle after done; the IDLE->ISSUE decision is registered.
//   Latency: a req at cycle t on an idle system gives ctrl enable high at t+2.
//     Done follows the controller's own read/write duration plus 1 cycle.
//   A req arriving in the same cycle as a grant decision is not eligible until it is
//     latched (next cycle).
//   Only one command is in flight at any time. A port's payload never changes while it is
//     pending.
//   Reset mid-operation: pending and FSM cleared immediately; enables drop to 0. The
//     controller has no reset. After reset deasserts, IDLE issues nothing until
//     ctrl_busy=0, so an aborted transfer finishes first and its result is discarded.
//   ctrl_write_high_byte/low_byte: for a write, driven from pN_be; for a read, both 0.
//
// TESTING
//   Single read p1 addr 0x012345 bank 1; model returns 0xBEEF -> ctrl_read_en high 2
//     cycles after req, then p1_done=1 with p1_rdata=0xBEEF, and p1_busy falls together.
//   Single write p0 addr 0x3FFFFF data 0xA55A be=2'b01 -> ctrl_write_low_byte=1,
//     ctrl_write_high_byte=0, exactly one write_en acceptance, p0_done once.
//   FIXED_PRIORITY=0: p0,p1,p2 req in the same cycle, each re-requests on done ->
//     grant order 0,1,2,0,1,2 (RESET_GRANT=2).
//   FIXED_PRIORITY=1: p2 and p0 pending together -> p0 served first, then p2.
//   p1_req pulsed again while p1_busy=1 with a different addr -> ignored; the original
//     addr is issued; only one p1_done.
//   reset asserted mid-write (ctrl_busy=1) -> all outputs 0; after release a pending p2
//     read is issued only after ctrl_busy=0.

Source files
------------

// File: rtl/psram_arbiter.sv
// psram_arbiter: shares one asynchronous PSRAM controller between three requesters.
// Each port latches a single-cycle request; one command is in flight at a time and
// the winner is picked by fixed priority or round-robin.
`timescale 1ns/1ps

module psram_arbiter #(
    parameter int FIXED_PRIORITY = 0,
    parameter int RESET_GRANT    = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic        p0_bank,
    input  logic [21:0] p0_addr,
    input  logic [15:0] p0_wdata,
    input  logic [1:0]  p0_be,
    output logic        p0_busy,
    output logic        p0_done,
    output logic [15:0] p0_rdata,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic        p1_bank,
    input  logic [21:0] p1_addr,
    input  logic [15:0] p1_wdata,
    input  logic [1:0]  p1_be,
    output logic        p1_busy,
    output logic        p1_done,
    output logic [15:0] p1_rdata,

    input  logic        p2_req,
    input  logic        p2_we,
    input  logic        p2_bank,
    input  logic [21:0] p2_addr,
    input  logic [15:0] p2_wdata,
    input  logic [1:0]  p2_be,
    output logic        p2_busy,
    output logic        p2_done,
    output logic [15:0] p2_rdata,

    output logic        ctrl_bank_sel,
    output logic [21:0] ctrl_addr,
    output logic [15:0] ctrl_data_in,
    output logic        ctrl_write_high_byte,
    output logic        ctrl_write_low_byte,
    output logic        ctrl_write_en,
    output logic        ctrl_read_en,
    input  logic        ctrl_write_ack,
    input  logic        ctrl_read_ack,
    input  logic        ctrl_read_avail,
    input  logic [15:0] ctrl_data_out,
    input  logic        ctrl_busy
);

    localparam int unsigned NP = 3;
    localparam int unsigned AW = 22;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 2;
    localparam int unsigned PW = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Flattened view of the three request ports.
    logic [NP-1:0]         req_v;
    logic [NP-1:0]         we_v;
    logic [NP-1:0]         bank_v;
    logic [NP-1:0][AW-1:0] addr_v;
    logic [NP-1:0][DW-1:0] wdata_v;
    logic [NP-1:0][BW-1:0] be_v;

    assign req_v   = {p2_req,   p1_req,   p0_req};
    assign we_v    = {p2_we,    p1_we,    p0_we};
    assign bank_v  = {p2_bank,  p1_bank,  p0_bank};
    assign addr_v  = {p2_addr,  p1_addr,  p0_addr};
    assign wdata_v = {p2_wdata, p1_wdata, p0_wdata};
    assign be_v    = {p2_be,    p1_be,    p0_be};

    // Latched per-port payloads; frozen while the port is pending.
    logic [NP-1:0]         pend;
    logic [NP-1:0]         pl_we;
    logic [NP-1:0]         pl_bank;
    logic [NP-1:0][AW-1:0] pl_addr;
    logic [NP-1:0][DW-1:0] pl_wdata;
    logic [NP-1:0][BW-1:0] pl_be;

    // FSM and arbitration state.
    logic [1:0]            state,  state_d;
    logic [PW-1:0]         ptr,    ptr_d;
    logic [PW-1:0]         cur,    cur_d;
    logic                  cur_we, cur_we_d;
    logic [PW-1:0]         win_sel;
    logic [PW-1:0]         cand1,  cand2;

    // Next values of the registered outputs.
    logic                  bank_d;
    logic [AW-1:0]         addr_d;
    logic [DW-1:0]         din_d;
    logic                  hb_d,   lb_d;
    logic                  wen_d,  ren_d;
    logic [NP-1:0]         done_d, done_q;
    logic [NP-1:0][DW-1:0] rdata_d, rdata_q;

    function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Per-port request latch: accept only while idle, clear on completion.
    for (genvar i = 0; i < NP; i++) begin : g_port
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pend[i]     <= 1'b0;
                pl_we[i]    <= 1'b0;
                pl_bank[i]  <= 1'b0;
                pl_addr[i]  <= '0;
                pl_wdata[i] <= '0;
                pl_be[i]    <= '0;
            end else if (req_v[i] && !pend[i]) begin
                pend[i]     <= 1'b1;
                pl_we[i]    <= we_v[i];
                pl_bank[i]  <= bank_v[i];
                pl_addr[i]  <= addr_v[i];
                pl_wdata[i] <= wdata_v[i];
                pl_be[i]    <= be_v[i];
            end else if (done_d[i]) begin
                pend[i]     <= 1'b0;
            end
        end
    end

    // Winner selection among pending ports.
    always_comb begin
        cand1   = rr_next(ptr);
        cand2   = rr_next(cand1);
        win_sel = ptr;
        if (FIXED_PRIORITY != 0) begin
            if (pend[0])      win_sel = 2'd0;
            else if (pend[1]) win_sel = 2'd1;
            else              win_sel = 2'd2;
        end else begin
            if (pend[cand1])      win_sel = cand1;
            else if (pend[cand2]) win_sel = cand2;
            else                  win_sel = ptr;
        end
    end

    // Next-state and output logic of the command FSM.
    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        cur_d    = cur;
        cur_we_d = cur_we;
        bank_d   = ctrl_bank_sel;
        addr_d   = ctrl_addr;
        din_d    = ctrl_data_in;
        hb_d     = ctrl_write_high_byte;
        lb_d     = ctrl_write_low_byte;
        wen_d    = ctrl_write_en;
        ren_d    = ctrl_read_en;
        done_d   = '0;
        rdata_d  = rdata_q;

        case (state)
            ST_IDLE: begin
                // ctrl_busy also covers a transfer orphaned by a reset.
                if ((|pend) && !ctrl_busy) begin
                    state_d  = ST_ISSUE;
                    ptr_d    = win_sel;
                    cur_d    = win_sel;
                    cur_we_d = pl_we[win_sel];
                    bank_d   = pl_bank[win_sel];
                    addr_d   = pl_addr[win_sel];
                    din_d    = pl_wdata[win_sel];
                    hb_d     = pl_we[win_sel] & pl_be[win_sel][1];
                    lb_d     = pl_we[win_sel] & pl_be[win_sel][0];
                    wen_d    = pl_we[win_sel];
                    ren_d    = !pl_we[win_sel];
                end
            end
            ST_ISSUE: begin
                // Drop the enables on ack so the command cannot relaunch.
                if (ctrl_write_ack || ctrl_read_ack) begin
                    wen_d   = 1'b0;
                    ren_d   = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cur_we) begin
                    if (!ctrl_write_ack && !ctrl_busy) begin
                        done_d[cur] = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else if (ctrl_read_avail) begin
                    done_d[cur]  = 1'b1;
                    rdata_d[cur] = ctrl_data_out;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wen_d   = 1'b0;
                ren_d   = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= ST_IDLE;
            ptr                  <= PW'(RESET_GRANT);
            cur                  <= '0;
            cur_we               <= 1'b0;
            ctrl_bank_sel        <= 1'b0;
            ctrl_addr            <= '0;
            ctrl_data_in         <= '0;
            ctrl_write_high_byte <= 1'b0;
            ctrl_write_low_byte  <= 1'b0;
            ctrl_write_en        <= 1'b0;
            ctrl_read_en         <= 1'b0;
            done_q               <= '0;
            rdata_q              <= '0;
        end else begin
            state                <= state_d;
            ptr                  <= ptr_d;
            cur                  <= cur_d;
            cur_we               <= cur_we_d;
            ctrl_bank_sel        <= bank_d;
            ctrl_addr            <= addr_d;
            ctrl_data_in         <= din_d;
            ctrl_write_high_byte <= hb_d;
            ctrl_write_low_byte  <= lb_d;
            ctrl_write_en        <= wen_d;
            ctrl_read_en         <= ren_d;
            done_q               <= done_d;
            rdata_q              <= rdata_d;
        end
    end

    assign p0_busy  = pend[0];
    assign p1_busy  = pend[1];
    assign p2_busy  = pend[2];
    assign p0_done  = done_q[0];
    assign p1_done  = done_q[1];
    assign p2_done  = done_q[2];
    assign p0_rdata = rdata_q[0];
    assign p1_rdata = rdata_q[1];
    assign p2_rdata = rdata_q[2];

endmodule

// File: tb/tb_psram_arbiter.sv
// Testbench for psram_arbiter: a round-robin and a fixed-priority instance, each
// driving its own behavioural PSRAM controller model, checked against scoreboards.
`timescale 1ns/1ps

module tb_psram_arbiter;

    localparam int LAT = 6;

    typedef struct packed {
        logic        we;
        logic        bank;
        logic [21:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
    } iss_t;

    typedef struct packed {
        logic [1:0]  port;
        logic        rd;
        logic [15:0] data;
    } dn_t;

    logic clk = 1'b0;
    logic rst;

    logic [2:0]  req   [2];
    logic [2:0]  we    [2];
    logic [2:0]  bank  [2];
    logic [21:0] addr  [2][3];
    logic [15:0] wdata [2][3];
    logic [1:0]  be    [2][3];

    wire [2:0]  busy  [2];
    wire [2:0]  done  [2];
    wire [15:0] rdata [2][3];

    wire [1:0]  c_bank, c_hb, c_lb, c_wen, c_ren;
    wire [21:0] c_addr [2];
    wire [15:0] c_din  [2];
    wire [1:0]  m_wack, m_rack, m_avail, m_busy;
    wire [15:0] m_dout [2];

    iss_t q_iss0[$], q_iss1[$];
    dn_t  q_dn0[$],  q_dn1[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   [2];
    int n_done  [2][3];

    always #5 clk = ~clk;

    function automatic logic [15:0] rd_value(input logic [22:0] key);
        if (key == 23'h412345) return 16'hBEEF;
        return key[15:0] ^ 16'hC3A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    psram_arbiter #(.FIXED_PRIORITY(0), .RESET_GRANT(2)) u_rr (
        .clk(clk), .reset(rst),
        .p0_req(req[0][0]), .p0_we(we[0][0]), .p0_bank(bank[0][0]), .p0_addr(addr[0][0]),
        .p0_wdata(wdata[0][0]), .p0_be(be[0][0]),
        .p0_busy(busy[0][0]), .p0_done(done[0][0]), .p0_rdata(rdata[0][0]),
        .p1_req(req[0][1]), .p1_we(we[0][1]), .p1_bank(bank[0][1]), .p1_addr(addr[0][1]),
        .p1_wdata(wdata[0][1]), .p1_be(be[0][1]),
        .p1_busy(busy[0][1]), .p1_done(done[0][1]), .p1_rdata(rdata[0][1]),
        .p2_req(req[0][2]), .p2_we(we[0][2]), .p2_bank(bank[0][2]), .p2_addr(addr[0][2]),
        .p2_wdata(wdata[0][2]), .p2_be(be[0][2]),
        .p2_busy(busy[0][2]), .p2_done(done[0][2]), .p2_rdata(rdata[0][2]),
        .ctrl_bank_sel(c_bank[0]), .ctrl_addr(c_addr[0]), .ctrl_data_in(c_din[0]),
        .ctrl_write_high_byte(c_hb[0]), .ctrl_write_low_byte(c_lb[0]),
        .ctrl_write_en(c_wen[0]), .ctrl_read_en(c_ren[0]),
        .ctrl_write_ack(m_wack[0]), .ctrl_read_ack(m_rack[0]), .ctrl_read_avail(m_avail[0]),
        .ctrl_data_out(m_dout[0]), .ctrl_busy(m_busy[0])
    );

    psram_arbiter #(.FIXED_PRIORITY(1), .RESET_GRANT(2)) u_fp (
        .clk(clk), .reset(rst),
        .p0_req(req[1][0]), .p0_we(we[1][0]), .p0_bank(bank[1][0]), .p0_addr(addr[1][0]),
        .p0_wdata(wdata[1][0]), .p0_be(be[1][0]),
        .p0_busy(busy[1][0]), .p0_done(done[1][0]), .p0_rdata(rdata[1][0]),
        .p1_req(req[1][1]), .p1_we(we[1][1]), .p1_bank(bank[1][1]), .p1_addr(addr[1][1]),
        .p1_wdata(wdata[1][1]), .p1_be(be[1][1]),
        .p1_busy(busy[1][1]), .p1_done(done[1][1]), .p1_rdata(rdata[1][1]),
        .p2_req(req[1][2]), .p2_we(we[1][2]), .p2_bank(bank[1][2]), .p2_addr(addr[1][2]),
        .p2_wdata(wdata[1][2]), .p2_be(be[1][2]),
        .p2_busy(busy[1][2]), .p2_done(done[1][2]), .p2_rdata(rdata[1][2]),
        .ctrl_bank_sel(c_bank[1]), .ctrl_addr(c_addr[1]), .ctrl_data_in(c_din[1]),
        .ctrl_write_high_byte(c_hb[1]), .ctrl_write_low_byte(c_lb[1]),
        .ctrl_write_en(c_wen[1]), .ctrl_read_en(c_ren[1]),
        .ctrl_write_ack(m_wack[1]), .ctrl_read_ack(m_rack[1]), .ctrl_read_avail(m_avail[1]),
        .ctrl_data_out(m_dout[1]), .ctrl_busy(m_busy[1])
    );

    // Controller model per instance: accept when idle, ack for one cycle, busy LAT+1
    // cycles, then pulse read_avail for reads. It has no reset, like the real one.
    for (genvar k = 0; k < 2; k++) begin : g_ctrl
        logic        busy_r = 1'b0, wack_r = 1'b0, rack_r = 1'b0, avail_r = 1'b0, we_r = 1'b0;
        logic [3:0]  cnt_r  = '0;
        logic [22:0] key_r  = '0;
        logic [15:0] dout_r = '0;
        always @(posedge clk) begin
            wack_r  <= 1'b0;
            rack_r  <= 1'b0;
            avail_r <= 1'b0;
            if (!busy_r) begin
                if (c_wen[k] || c_ren[k]) begin
                    busy_r <= 1'b1;
                    cnt_r  <= 4'(LAT);
                    we_r   <= c_wen[k];
                    key_r  <= {c_bank[k], c_addr[k]};
                    if (c_wen[k]) wack_r <= 1'b1;
                    else          rack_r <= 1'b1;
                end
            end else if (cnt_r == 4'd0) begin
                busy_r <= 1'b0;
                if (!we_r) begin
                    avail_r <= 1'b1;
                    dout_r  <= rd_value(key_r);
                end
            end else begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
        assign m_busy[k]  = busy_r;
        assign m_wack[k]  = wack_r;
        assign m_rack[k]  = rack_r;
        assign m_avail[k] = avail_r;
        assign m_dout[k]  = dout_r;
    end

    // Scoreboard monitors: command acceptance and per-port completion.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (!m_busy[k] && (c_wen[k] || c_ren[k])) begin
                    iss_t e;
                    logic has;
                    n_acc[k]++;
                    has = (k == 0) ? (q_iss0.size() > 0) : (q_iss1.size() > 0);
                    chk("issue_expected", 32'(has), 32'd1);
                    if (has) begin
                        if (k == 0) e = q_iss0.pop_front();
                        else        e = q_iss1.pop_front();
                        chk("issue_wen",  32'(c_wen[k]),  32'(e.we));
                        chk("issue_ren",  32'(c_ren[k]),  32'(!e.we));
                        chk("issue_bank", 32'(c_bank[k]), 32'(e.bank));
                        chk("issue_addr", 32'(c_addr[k]), 32'(e.addr));
                        if (e.we) begin
                            chk("issue_wdata", 32'(c_din[k]), 32'(e.wdata));
                            chk("issue_hb", 32'(c_hb[k]), 32'(e.be[1]));
                            chk("issue_lb", 32'(c_lb[k]), 32'(e.be[0]));
                        end else begin
                            chk("issue_rd_hb", 32'(c_hb[k]), 32'd0);
                            chk("issue_rd_lb", 32'(c_lb[k]), 32'd0);
                        end
                    end
                end
                for (int p = 0; p < 3; p++) begin
                    if (done[k][p]) begin
                        dn_t d;
                        logic has;
                        n_done[k][p]++;
                        has = (k == 0) ? (q_dn0.size() > 0) : (q_dn1.size() > 0);
                        chk("done_expected", 32'(has), 32'd1);
                        chk("done_busy_low", 32'(busy[k][p]), 32'd0);
                        if (has) begin
                            if (k == 0) d = q_dn0.pop_front();
                            else        d = q_dn1.pop_front();
                            chk("done_port", 32'(p), 32'(d.port));
                            if (d.rd) chk("done_rdata", 32'(rdata[k][p]), 32'(d.data));
                        end
                    end
                end
            end
        end
    end

    // Drive a request on instance k, port p and record its expected outcome.
    task automatic arm(input int k, input int p, input logic w, input logic b,
                       input logic [21:0] a, input logic [15:0] wd, input logic [1:0] bb);
        iss_t e;
        dn_t  d;
        req[k][p]   = 1'b1;
        we[k][p]    = w;
        bank[k][p]  = b;
        addr[k][p]  = a;
        wdata[k][p] = wd;
        be[k][p]    = bb;
        e = '{we: w, bank: b, addr: a, wdata: wd, be: bb};
        d = '{port: 2'(p), rd: !w, data: rd_value({b, a})};
        if (k == 0) begin q_iss0.push_back(e); q_dn0.push_back(d); end
        else        begin q_iss1.push_back(e); q_dn1.push_back(d); end
    endtask

    task automatic step();
        @(negedge clk);
        req[0] = '0;
        req[1] = '0;
    endtask

    task automatic wait_done(input int k, input int p, input string tag);
        int n = 0;
        while (!done[k][p] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done[k][p]), 32'd1);
    endtask

    function automatic int dsum(input int k);
        return n_done[k][0] + n_done[k][1] + n_done[k][2];
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, dn0, dn1, base, guard, viol;
        int rem [3];

        for (int k = 0; k < 2; k++) begin
            req[k] = '0; we[k] = '0; bank[k] = '0; n_acc[k] = 0;
            for (int p = 0; p < 3; p++) begin
                addr[k][p] = '0; wdata[k][p] = '0; be[k][p] = '0; n_done[k][p] = 0;
            end
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_busy",  32'(busy[0]),    32'd0);
        chk("rst_done",  32'(done[0]),    32'd0);
        chk("rst_wen",   32'(c_wen[0]),   32'd0);
        chk("rst_ren",   32'(c_ren[0]),   32'd0);
        chk("rst_addr",  32'(c_addr[0]),  32'd0);
        chk("rst_rdata", 32'(rdata[0][1]), 32'd0);
        chk("rst_fp_busy", 32'(busy[1]),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Round-robin: all three at once, each re-requests on done -> 0,1,2,0,1,2.
        base = dsum(0);
        arm(0, 0, 1'b1, 1'b0, 22'h100000, 16'h1000, 2'b11);
        arm(0, 1, 1'b0, 1'b0, 22'h100001, 16'h0000, 2'b11);
        arm(0, 2, 1'b0, 1'b1, 22'h100002, 16'h0000, 2'b11);
        step();
        for (int p = 0; p < 3; p++) rem[p] = 1;
        guard = 0;
        while (dsum(0) - base < 6 && guard < 400) begin
            @(negedge clk);
            guard++;
            req[0] = '0;
            for (int p = 0; p < 3; p++) begin
                if (done[0][p] && rem[p] > 0) begin
                    rem[p]--;
                    arm(0, p, (p == 0), 1'b0, 22'h100010 + 22'(p), 16'h2000 + 16'(p), 2'b10);
                end
            end
        end
        chk("rr_all_done", 32'(dsum(0) - base), 32'd6);
        chk("rr_queue_empty", 32'(q_iss0.size()), 32'd0);

        // Single read on p1: enable two cycles after req, done with 0xBEEF.
        arm(0, 1, 1'b0, 1'b1, 22'h012345, 16'h0000, 2'b11);
        step();
        chk("rd_busy_t1", 32'(busy[0][1]), 32'd1);
        chk("rd_ren_t1",  32'(c_ren[0]),   32'd0);
        @(negedge clk);
        chk("rd_ren_t2",  32'(c_ren[0]),   32'd1);
        chk("rd_addr_t2", 32'(c_addr[0]),  32'h012345);
        chk("rd_bank_t2", 32'(c_bank[0]),  32'd1);
        wait_done(0, 1, "rd");
        chk("rd_rdata",   32'(rdata[0][1]), 32'hBEEF);
        chk("rd_busy_fall", 32'(busy[0][1]), 32'd0);
        @(negedge clk);
        chk("rd_rdata_held", 32'(rdata[0][1]), 32'hBEEF);

        // Single write on p0 at the top address, low byte only.
        acc0 = n_acc[0];
        dn0  = n_done[0][0];
        arm(0, 0, 1'b1, 1'b0, 22'h3FFFFF, 16'hA55A, 2'b01);
        step();
        @(negedge clk);
        chk("wr_wen", 32'(c_wen[0]), 32'd1);
        chk("wr_lb",  32'(c_lb[0]),  32'd1);
        chk("wr_hb",  32'(c_hb[0]),  32'd0);
        chk("wr_din", 32'(c_din[0]), 32'hA55A);
        wait_done(0, 0, "wr");
        repeat (12) @(negedge clk);
        chk("wr_one_accept", 32'(n_acc[0] - acc0), 32'd1);
        chk("wr_one_done",   32'(n_done[0][0] - dn0), 32'd1);

        // Request while busy is ignored: the original address is issued once.
        dn1 = n_done[0][1];
        arm(0, 1, 1'b0, 1'b0, 22'h000111, 16'h0000, 2'b11);
        step();
        req[0][1]  = 1'b1;
        addr[0][1] = 22'h2AAAAA;
        step();
        chk("ign_addr", 32'(c_addr[0]), 32'h000111);
        wait_done(0, 1, "ign");
        repeat (20) @(negedge clk);
        chk("ign_one_done", 32'(n_done[0][1] - dn1), 32'd1);
        chk("ign_not_busy", 32'(busy[0][1]), 32'd0);

        // Fixed priority: move the pointer to p0, then p2 and p0 together -> p0 first.
        arm(1, 0, 1'b1, 1'b0, 22'h200100, 16'h7777, 2'b11);
        step();
        wait_done(1, 0, "fp_warm");
        @(negedge clk);
        arm(1, 0, 1'b0, 1'b0, 22'h200000, 16'h0000, 2'b11);
        arm(1, 2, 1'b0, 1'b1, 22'h200002, 16'h0000, 2'b11);
        step();
        wait_done(1, 0, "fp_p0");
        chk("fp_p2_still_pending", 32'(busy[1][2]), 32'd1);
        wait_done(1, 2, "fp_p2");
        chk("fp_queue_empty", 32'(q_iss1.size()), 32'd0);

        // Reset during a write while the controller is busy.
        dn0 = n_done[0][0];
        arm(0, 0, 1'b1, 1'b0, 22'h155555, 16'h1234, 2'b11);
        step();
        guard = 0;
        while (!m_wack[0] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_mid_ack_seen", 32'(m_wack[0]), 32'd1);
        rst = 1'b1;
        q_dn0.delete();
        #1;
        chk("rstm_busy", 32'(busy[0]),   32'd0);
        chk("rstm_done", 32'(done[0]),   32'd0);
        chk("rstm_wen",  32'(c_wen[0]),  32'd0);
        chk("rstm_ren",  32'(c_ren[0]),  32'd0);
        chk("rstm_addr", 32'(c_addr[0]), 32'd0);
        chk("rstm_din",  32'(c_din[0]),  32'd0);
        chk("rstm_bank", 32'(c_bank[0]), 32'd0);
        chk("rstm_lanes", 32'({c_hb[0], c_lb[0]}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        arm(0, 2, 1'b0, 1'b0, 22'h0ABCDE, 16'h0000, 2'b11);
        step();
        chk("rstm_p0_cleared", 32'(busy[0][0]), 32'd1 - 32'd1);
        chk("rstm_p2_pending", 32'(busy[0][2]), 32'd1);
        viol  = 0;
        guard = 0;
        while (m_busy[0] && guard < 50) begin
            if (c_ren[0] || c_wen[0]) viol++;
            @(negedge clk);
            guard++;
        end
        chk("rstm_no_issue_while_busy", 32'(viol), 32'd0);
        chk("rstm_ctrl_went_idle", 32'(m_busy[0]), 32'd0);
        wait_done(0, 2, "rstm_p2");
        repeat (12) @(negedge clk);
        chk("rstm_no_p0_done", 32'(n_done[0][0] - dn0), 32'd0);

        chk("end_iss0", 32'(q_iss0.size()), 32'd0);
        chk("end_dn0",  32'(q_dn0.size()),  32'd0);
        chk("end_dn1",  32'(q_dn1.size()),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
